pool_ctrl: RTL and testbench

Window sequencer that sits directly upstream of the max-pool stage and also consumes its result.
- Accepts a ready/valid stream of signed numbers, grouped into windows of cfg_size consecutive elements.
- Drives the pool stage's restart/up_valid/up_data.
- Captures the pool stage's held maximum at the exact cycle each window's result settles.
- Re-emits each result on a ready/valid output through a small FIFO, with credit-based backpressure.

---
 rtl/pool_ctrl_if.sv | 29 ++
 rtl/pool_ctrl.sv | 92 +++++++++
 tb/tb_pool_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_ctrl_if.sv
// Handshake bundle between the window sequencer, its element source, the
// max-pool stage and the result consumer.
interface pool_ctrl_if #(
   parameter int NUM_WIDTH  = 16,
   parameter int SIZE_WIDTH = 8
) ();
   logic        [SIZE_WIDTH-1:0] cfg_size;
   logic signed [NUM_WIDTH-1:0]  up_data;
   logic                         up_valid;
   logic                         up_ready;
   logic                         pool_restart;
   logic signed [NUM_WIDTH-1:0]  pool_data;
   logic                         pool_valid;
   logic signed [NUM_WIDTH-1:0]  pool_result;
   logic signed [NUM_WIDTH-1:0]  dn_data;
   logic                         dn_valid;
   logic                         dn_ready;

   // Environment side: element source, pool stage result and result sink.
   modport master (
      output cfg_size, up_data, up_valid, pool_result, dn_ready,
      input  up_ready, pool_restart, pool_data, pool_valid, dn_data, dn_valid
   );

   modport slave (
      input  cfg_size, up_data, up_valid, pool_result, dn_ready,
      output up_ready, pool_restart, pool_data, pool_valid, dn_data, dn_valid
   );
endinterface

// File: rtl/pool_ctrl.sv
// Window sequencer for the max-pool stage: frames the element stream into
// windows, captures each settled window maximum and re-emits it via a FIFO.
module pool_ctrl #(
   parameter int NUM_WIDTH  = 16,
   parameter int SIZE_WIDTH = 8,
   parameter int OUT_DEPTH  = 4
) (
   input logic        clk,
   input logic        rst,
   pool_ctrl_if.slave bus
);
   localparam int AW = $clog2(OUT_DEPTH);
   localparam int CW = AW + 2;

   logic        [SIZE_WIDTH-1:0] elem_cnt;
   logic        [SIZE_WIDTH-1:0] size;
   logic        [SIZE_WIDTH-1:0] cur_size;
   logic                         is_last;
   logic                         accept;
   logic        [3:0]            last_dl;
   logic signed [NUM_WIDTH-1:0]  mem [OUT_DEPTH];
   logic        [AW-1:0]         wr_ptr;
   logic        [AW-1:0]         rd_ptr;
   logic        [AW:0]           count;
   logic        [CW-1:0]         credits_used;
   logic                         push;
   logic                         pop;

   // On the first element of a window the size comes straight from cfg_size,
   // so the last-element decision is correct even for single-element windows.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      cur_size = size;
      if (elem_cnt == '0)
         cur_size = (bus.cfg_size == '0) ? SIZE_WIDTH'(1) : bus.cfg_size;
      is_last = (elem_cnt == cur_size - SIZE_WIDTH'(1));
   end

   // Results still in the pool pipeline already own a FIFO slot.
   assign credits_used = CW'(count) + CW'(last_dl[0]) + CW'(last_dl[1])
                       + CW'(last_dl[2]) + CW'(last_dl[3]);

   assign bus.up_ready     = !rst && !(is_last && (credits_used >= CW'(OUT_DEPTH)));
   assign accept           = bus.up_valid && bus.up_ready;
   assign bus.pool_data    = bus.up_data;
   assign bus.pool_valid   = accept;
   assign bus.pool_restart = accept && (elem_cnt == '0);

   assign push         = last_dl[3];
   assign bus.dn_valid = (count != '0);
   assign pop          = bus.dn_valid && bus.dn_ready;
   assign bus.dn_data  = bus.dn_valid ? mem[rd_ptr] : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         elem_cnt <= '0;
         size     <= '0;
         last_dl  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         last_dl <= {last_dl[2:0], accept && is_last};
         if (accept) begin
            if (elem_cnt == '0)
               size <= cur_size;
            elem_cnt <= is_last ? '0 : elem_cnt + SIZE_WIDTH'(1);
         end
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Slot 4 of the delay line lines up with the cycle the pool's held max
   // is final; the next window may overwrite it on this very edge.
   // NOTE: the FIFO storage is not reset; the pointers and count are, so
   // stale entries are never visible.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.pool_result;
   end
endmodule

// File: tb/tb_pool_ctrl.sv
// Self-checking bench for pool_ctrl: behavioural pool stage, window-level
// reference model feeding a result scoreboard, and an independent monitor.
module tb_pool_ctrl;
   localparam int NW = 16;
   localparam int SW = 8;
   localparam int OD = 4;

   typedef struct {
      longint val;
      longint t_last;
   } res_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   longint cyc = 0;
   int     checks = 0;
   int     failures = 0;

   res_t   exp_q[$];
   int     n_issued = 0;
   int     n_popped = 0;
   bit     chk_lat = 1'b0;
   bit     rand_dn = 1'b0;
   longint last_out = 0;

   // Window-level reference state.
   int     pos = 0;
   int     win_size = 1;
   longint cur_max = 0;
   int     acc_cnt = 0;
   int     stall_at = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pool_ctrl_if #(.NUM_WIDTH(NW), .SIZE_WIDTH(SW)) bus ();

   pool_ctrl #(.NUM_WIDTH(NW), .SIZE_WIDTH(SW), .OUT_DEPTH(OD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Pool stage: three input pipeline stages, then a held running maximum.
   logic signed [NW-1:0] pd1 = '0, pd2 = '0, pd3 = '0, pmax = '0;
   logic pv1 = 1'b0, pv2 = 1'b0, pv3 = 1'b0;
   logic pr1 = 1'b0, pr2 = 1'b0, pr3 = 1'b0;

   always @(posedge clk) begin
      pv1 <= bus.pool_valid;   pr1 <= bus.pool_restart; pd1 <= bus.pool_data;
      pv2 <= pv1;              pr2 <= pr1;              pd2 <= pd1;
      pv3 <= pv2;              pr3 <= pr2;              pd3 <= pd2;
      if (pv3)
         pmax <= (pr3 || (pd3 > pmax)) ? pd3 : pmax;
   end
   assign bus.pool_result = pmax;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_is_last(input int cfg);
      int eff;
      eff = (pos == 0) ? ((cfg == 0) ? 1 : cfg) : win_size;
      return pos == eff - 1;
   endfunction

   function automatic bit model_ready(input int cfg);
      return !(model_is_last(cfg) && ((n_issued - n_popped) >= OD));
   endfunction

   // Offer one element; returns once it has been accepted (or the bound expires).
   task automatic send(input int d, input int cfg);
      bus.up_valid = 1'b1;
      bus.up_data  = NW'(d);
      bus.cfg_size = SW'(cfg);
      for (int w = 0; w < 200; w++) begin
         @(negedge clk);
         check("up_ready", bus.up_ready, model_ready(cfg));
         if (bus.up_ready) begin
            check("pool_valid", bus.pool_valid, 1);
            check("pool_restart", bus.pool_restart, pos == 0);
            check("pool_data", bus.pool_data, d);
            if (pos == 0) begin
               win_size = (cfg == 0) ? 1 : cfg;
               cur_max  = d;
            end else if (d > cur_max) begin
               cur_max = d;
            end
            pos++;
            acc_cnt++;
            if (pos == win_size) begin
               exp_q.push_back('{val: cur_max, t_last: cyc});
               n_issued++;
               pos = 0;
            end
            @(posedge clk); #1;
            bus.up_valid = 1'b0;
            return;
         end
         check("pool_valid_stalled", bus.pool_valid, 0);
         if (stall_at == 0) stall_at = acc_cnt + 1;
         @(posedge clk); #1;
         if (rand_dn) bus.dn_ready = ($urandom_range(0, 1) != 0);
      end
      check("send_timeout", 1, 0);
      bus.up_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.up_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("idle_up_ready", bus.up_ready, model_ready(int'(bus.cfg_size)));
         check("idle_pool_valid", bus.pool_valid, 0);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      bus.up_valid = 1'b1;
      bus.up_data  = NW'(77);
      @(negedge clk);
      check("rst_up_ready", bus.up_ready, 0);
      check("rst_pool_valid", bus.pool_valid, 0);
      check("rst_pool_restart", bus.pool_restart, 0);
      exp_q.delete();
      n_issued = 0;
      n_popped = 0;
      pos = 0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      bus.up_valid = 1'b0;
      @(negedge clk);
      check("rst_dn_valid", bus.dn_valid, 0);
      check("rst_dn_data", bus.dn_data, 0);
      @(posedge clk); #1;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      check("drain_left", exp_q.size(), 0);
      idle(3);
   endtask

   // Monitor: pops the scoreboard whenever the DUT hands a result off.
   initial begin
      res_t   r;
      longint exp_c;
      forever begin
         @(negedge clk);
         if (!rst && bus.dn_valid && bus.dn_ready) begin
            if (exp_q.size() == 0) begin
               check("dn_unexpected_valid", bus.dn_valid, 0);
            end else begin
               r = exp_q.pop_front();
               check("dn_data", bus.dn_data, r.val);
               if (chk_lat) begin
                  exp_c = (r.t_last + 5 > last_out + 1) ? r.t_last + 5 : last_out + 1;
                  check("dn_latency", cyc, exp_c);
               end
               last_out = cyc;
               @(posedge clk);
               n_popped++;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      int cfg;
      int vals2[8] = '{3, -7, 12, 5, -2, -9, -1, -4};

      bus.up_valid = 1'b0;
      bus.up_data  = '0;
      bus.cfg_size = SW'(4);
      bus.dn_ready = 1'b1;
      @(posedge clk); #1;
      do_reset(3);

      // Two windows of four, continuous stream.
      chk_lat = 1'b1;
      foreach (vals2[i]) send(vals2[i], 4);
      wait_drain(50);

      // Single-element windows, back to back.
      for (int i = 0; i < 8; i++) send(i * 37 - 100, 1);
      wait_drain(50);

      // Credit stall with the consumer blocked.
      chk_lat = 1'b0;
      bus.dn_ready = 1'b0;
      acc_cnt = 0;
      stall_at = 0;
      for (int i = 1; i <= 9; i++) send(i * 11 - 50, 2);
      fork
         send(10 * 11 - 50, 2);
         begin
            repeat (8) @(posedge clk);
            #1;
            bus.dn_ready = 1'b1;
         end
      join
      check("stall_element", stall_at, 10);
      send(11 * 11 - 50, 2);
      send(12 * 11 - 50, 2);
      wait_drain(60);

      // Signed extremes.
      chk_lat = 1'b1;
      for (int i = 0; i < 3; i++) send(-32768, 3);
      send(-1, 3);
      send(0, 3);
      send(32767, 3);
      wait_drain(50);

      // Reset in the middle of a window.
      send(500, 4);
      send(600, 4);
      do_reset(1);
      for (int i = 1; i <= 4; i++) send(i, 4);
      wait_drain(50);

      // cfg_size change mid-window is ignored until the next window.
      send(10, 4);
      send(20, 2);
      send(30, 2);
      send(40, 2);
      send(7, 2);
      send(8, 2);
      wait_drain(50);

      // Randomised traffic with random sizes, gaps and consumer backpressure.
      chk_lat = 1'b0;
      rand_dn = 1'b1;
      for (int i = 0; i < 300; i++) begin
         d   = int'($urandom_range(0, 65535)) - 32768;
         cfg = int'($urandom_range(0, 5));
         bus.dn_ready = ($urandom_range(0, 3) != 0);
         send(d, cfg);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      rand_dn = 1'b0;
      bus.dn_ready = 1'b1;
      wait_drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
